// File: rtl/rank_cmd_arbiter_if.sv
// Bundle of the requester-side and Package-side signals of rank_cmd_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and the Package model.
interface rank_cmd_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int CMD_W    = 16,
    parameter int DATA_W   = 32,
    parameter int RD_DEPTH = 8
);
    localparam int CNT_W = $clog2(RD_DEPTH + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*CMD_W-1:0]  req_command;
    logic [NUM_REQ*DATA_W-1:0] req_write_data;
    logic                      pkg_valid;
    logic                      pkg_ready;
    logic [CMD_W-1:0]          pkg_command;
    logic [DATA_W-1:0]         pkg_write_data;
    logic [DATA_W-1:0]         pkg_read_data;
    logic                      pkg_read_data_valid;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [CNT_W-1:0]          rd_outstanding;
    logic                      err_underflow;

    modport slave (
        input  req_valid, req_command, req_write_data,
        input  pkg_ready, pkg_read_data, pkg_read_data_valid,
        output req_ready, pkg_valid, pkg_command, pkg_write_data,
        output rsp_valid, rsp_data, rd_outstanding, err_underflow
    );

    modport master (
        output req_valid, req_command, req_write_data,
        output pkg_ready, pkg_read_data, pkg_read_data_valid,
        input  req_ready, pkg_valid, pkg_command, pkg_write_data,
        input  rsp_valid, rsp_data, rd_outstanding, err_underflow
    );
endinterface

// File: rtl/rank_cmd_arbiter.sv
// Round-robin sharing of the Package command port among NUM_REQ requesters, with an in-order
// read-tag FIFO routing returned data. Define RANK_ARB_QOS_EN to give requester 0 strict priority.
module rank_cmd_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CMD_W    = 16,
    parameter int DATA_W   = 32,
    parameter int RW_BIT   = CMD_W - 3,
    parameter int RD_DEPTH = 8
) (
    input  logic              clk,
    input  logic              power_on_rst_n,
    rank_cmd_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CNT_W = $clog2(RD_DEPTH + 1);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              pkg_valid_q, pkg_valid_d;
    logic [CMD_W-1:0]  pkg_cmd_q, pkg_cmd_d;
    logic [DATA_W-1:0] pkg_wdata_q, pkg_wdata_d;

    logic [IDX_W-1:0]  tag_mem_q [RD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    logic               slot_free, fifo_full, fifo_empty;
    logic               accept, push, pop;
    logic [NUM_REQ-1:0] is_read, elig, gnt;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W:0]     cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign slot_free  = !pkg_valid_q || bus.pkg_ready;
    assign fifo_full  = (cnt_q == CNT_W'(RD_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // req_valid gates everything, so X on an idle requester's command never reaches the grant
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            is_read[i] = bus.req_command[i*CMD_W + RW_BIT];
            elig[i]    = bus.req_valid[i] & ~(is_read[i] & fifo_full);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (slot_free && power_on_rst_n) begin
`ifdef RANK_ARB_QOS_EN
            if (elig[0]) begin
                gnt_any = 1'b1;
            end
`endif
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
                if (cand >= NUM_REQ_W) begin
                    cand = cand - NUM_REQ_W;
                end
                if (!gnt_any && elig[cand[IDX_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign accept = gnt_any;
    assign push   = accept & is_read[gnt_idx];
    assign pop    = bus.pkg_read_data_valid & ~fifo_empty;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        pkg_valid_d = pkg_valid_q;
        pkg_cmd_d   = pkg_cmd_q;
        pkg_wdata_d = pkg_wdata_q;
        if (accept) begin
            pkg_valid_d = 1'b1;
            pkg_cmd_d   = bus.req_command[int'(gnt_idx)*CMD_W +: CMD_W];
            pkg_wdata_d = bus.req_write_data[int'(gnt_idx)*DATA_W +: DATA_W];
`ifdef RANK_ARB_QOS_EN
            if (gnt_idx != '0) begin
                rr_ptr_d = next_idx(gnt_idx);
            end
`else
            rr_ptr_d = next_idx(gnt_idx);
`endif
        end else if (bus.pkg_ready) begin
            pkg_valid_d = 1'b0;
        end
    end

    // Full blocks new reads even when a pop happens this cycle; the FIFO has no bypass path
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d                        = rd_ptr_q + 1'b1;
            rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rsp_data_d                      = bus.pkg_read_data;
        end
        if (bus.pkg_read_data_valid && fifo_empty) begin
            err_d = 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            rr_ptr_q    <= '0;
            pkg_valid_q <= 1'b0;
            pkg_cmd_q   <= '0;
            pkg_wdata_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pkg_valid_q <= pkg_valid_d;
            pkg_cmd_q   <= pkg_cmd_d;
            pkg_wdata_q <= pkg_wdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign bus.req_ready      = gnt;
    assign bus.pkg_valid      = pkg_valid_q;
    assign bus.pkg_command    = pkg_cmd_q;
    assign bus.pkg_write_data = pkg_wdata_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rd_outstanding = cnt_q;
    assign bus.err_underflow  = err_q;
endmodule
